// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station and the branch FU.
// Holds the branch-type encoding both sides agree on, the default station depth
// and a reference entry layout at the default widths.
package branch_rs_pkg;

  localparam int unsigned BR_RS_ENTRIES = 4;
  localparam int unsigned BR_WORD_W     = 32;
  localparam int unsigned BR_TAG_W      = 4;

  // Comparison class; the FU pairs each with gate_sel to pick the sense.
  typedef enum logic [1:0] {
    BrEqNe   = 2'd0,
    BrLtGe   = 2'd1,
    BrLtuGeu = 2'd2,
    BrRsvd   = 2'd3
  } br_type_e;

  typedef struct packed {
    logic                 valid;
    br_type_e             branch_type;
    logic                 gate_sel;
    logic [BR_WORD_W-1:0] pc;
    logic [BR_WORD_W-1:0] imm;
    logic [BR_WORD_W-1:0] rs1_val;
    logic                 rs1_rdy;
    logic [BR_TAG_W-1:0]  rs1_tag;
    logic [BR_WORD_W-1:0] rs2_val;
    logic                 rs2_rdy;
    logic [BR_TAG_W-1:0]  rs2_tag;
    logic [BR_TAG_W-1:0]  rob_tag;
  } branch_rs_entry_t;

endpackage

// File: rtl/branch_rs_select.sv
// Lowest-index-ready priority encoder for the branch reservation station.
// Ports:
//   ready_i  per-entry "valid and both operands ready"
//   found_o  at least one entry is ready
//   idx_o    index of the lowest ready entry (0 when none)
module branch_rs_select #(
  parameter int unsigned NumEntries = 4,
  localparam int unsigned IdxW      = $clog2(NumEntries)
) (
  input  logic [NumEntries-1:0] ready_i,
  output logic                  found_o,
  output logic [IdxW-1:0]       idx_o
);

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/branch_rs.sv
// Collapsing-queue reservation station feeding the branch FU.
// Entry 0 is the oldest; valid entries are contiguous from 0. Entries wait for both
// operands, snoop the CDB, and the oldest ready one moves into a registered
// valid/ready issue stage whose fields map straight onto the FU inputs.
// Ports:
//   CLK, nRST          clock, async active-low reset
//   flush              squash all entries and the issue register
//   disp_*             dispatch request/payload, disp_ready back-pressure
//   cdb_*              common data bus broadcast
//   iss_*              issue register outputs, iss_ready from the FU
//   count              occupied entries
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = BR_RS_ENTRIES,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned TAG_W       = 4,
  localparam int unsigned CntW       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [1:0]        disp_branch_type,
  input  logic              disp_gate_sel,
  input  logic [WORD_W-1:0] disp_pc,
  input  logic [WORD_W-1:0] disp_imm,
  input  logic [WORD_W-1:0] disp_rs1_val,
  input  logic [WORD_W-1:0] disp_rs2_val,
  input  logic              disp_rs1_rdy,
  input  logic              disp_rs2_rdy,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic [TAG_W-1:0]  disp_rob_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [WORD_W-1:0] cdb_value,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [1:0]        iss_branch_type,
  output logic              iss_gate_sel,
  output logic [WORD_W-1:0] iss_pc,
  output logic [WORD_W-1:0] iss_imm,
  output logic [WORD_W-1:0] iss_reg_a,
  output logic [WORD_W-1:0] iss_reg_b,
  output logic [TAG_W-1:0]  iss_rob_tag,
  output logic [CntW-1:0]   count
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic              valid;
    br_type_e          branch_type;
    logic              gate_sel;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] rs1_val;
    logic              rs1_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [WORD_W-1:0] rs2_val;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [TAG_W-1:0]  rob_tag;
  } entry_t;

  typedef struct packed {
    logic              valid;
    br_type_e          branch_type;
    logic              gate_sel;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] reg_a;
    logic [WORD_W-1:0] reg_b;
    logic [TAG_W-1:0]  rob_tag;
  } iss_t;

  entry_t                 ent_q [NUM_ENTRIES];
  entry_t                 ent_d [NUM_ENTRIES];
  entry_t                 woken [NUM_ENTRIES];
  entry_t                 disp_ent;
  iss_t                   iss_q, iss_d;
  logic [CntW-1:0]        count_q, count_d, wr_idx;
  logic [NUM_ENTRIES-1:0] cand;
  logic                   sel_found;
  logic [IdxW-1:0]        sel_idx;
  logic                   disp_fire, issue_fire;

  // No credit for a same-cycle issue: a full station refuses dispatch.
  assign disp_ready = (count_q < CntW'(NUM_ENTRIES)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
    end
  end

  branch_rs_select #(
    .NumEntries (NUM_ENTRIES)
  ) u_select (
    .ready_i (cand),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign issue_fire = sel_found && (!iss_q.valid || iss_ready);
  // The slot the new entry lands in after the issuing entry collapses out.
  assign wr_idx     = count_q - CntW'(issue_fire);

  // Incoming entry, with a same-cycle CDB bypass for operands not yet ready.
  always_comb begin
    disp_ent             = '0;
    disp_ent.valid       = 1'b1;
    disp_ent.branch_type = br_type_e'(disp_branch_type);
    disp_ent.gate_sel    = disp_gate_sel;
    disp_ent.pc          = disp_pc;
    disp_ent.imm         = disp_imm;
    disp_ent.rs1_val     = disp_rs1_val;
    disp_ent.rs1_rdy     = disp_rs1_rdy;
    disp_ent.rs1_tag     = disp_rs1_tag;
    disp_ent.rs2_val     = disp_rs2_val;
    disp_ent.rs2_rdy     = disp_rs2_rdy;
    disp_ent.rs2_tag     = disp_rs2_tag;
    disp_ent.rob_tag     = disp_rob_tag;
    if (!disp_rs1_rdy && cdb_valid && (cdb_tag == disp_rs1_tag)) begin
      disp_ent.rs1_val = cdb_value;
      disp_ent.rs1_rdy = 1'b1;
    end
    if (!disp_rs2_rdy && cdb_valid && (cdb_tag == disp_rs2_tag)) begin
      disp_ent.rs2_val = cdb_value;
      disp_ent.rs2_rdy = 1'b1;
    end
  end

  // Wakeup, then collapse around the issued entry, then append the dispatch.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woken[i] = ent_q[i];
      if (ent_q[i].valid && cdb_valid) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
          woken[i].rs1_val = cdb_value;
          woken[i].rs1_rdy = 1'b1;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
          woken[i].rs2_val = cdb_value;
          woken[i].rs2_rdy = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        ent_d[i] = woken[i+1];
      end else begin
        ent_d[i] = woken[i];
      end
    end
    // The top slot always empties on an issue, whichever entry left.
    ent_d[NUM_ENTRIES-1] = issue_fire ? '0 : woken[NUM_ENTRIES-1];

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (disp_fire && (int'(wr_idx) == i)) begin
        ent_d[i] = disp_ent;
      end
    end

    if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_d[i] = '0;
      end
    end
  end

  always_comb begin
    iss_d = iss_q;
    if (flush) begin
      iss_d.valid = 1'b0;
    end else if (issue_fire) begin
      iss_d.valid       = 1'b1;
      iss_d.branch_type = ent_q[sel_idx].branch_type;
      iss_d.gate_sel    = ent_q[sel_idx].gate_sel;
      iss_d.pc          = ent_q[sel_idx].pc;
      iss_d.imm         = ent_q[sel_idx].imm;
      iss_d.reg_a       = ent_q[sel_idx].rs1_val;
      iss_d.reg_b       = ent_q[sel_idx].rs2_val;
      iss_d.rob_tag     = ent_q[sel_idx].rob_tag;
    end else if (iss_ready) begin
      iss_d.valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q + CntW'(disp_fire) - CntW'(issue_fire);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      iss_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      iss_q   <= iss_d;
      count_q <= count_d;
    end
  end

  assign iss_valid       = iss_q.valid;
  assign iss_branch_type = iss_q.branch_type;
  assign iss_gate_sel    = iss_q.gate_sel;
  assign iss_pc          = iss_q.pc;
  assign iss_imm         = iss_q.imm;
  assign iss_reg_a       = iss_q.reg_a;
  assign iss_reg_b       = iss_q.reg_b;
  assign iss_rob_tag     = iss_q.rob_tag;
  assign count           = count_q;

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the station.
module tb_branch_rs;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int T  = 4;
  localparam int CW = $clog2(N + 1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          flush, disp_valid, disp_gate_sel, disp_rs1_rdy, disp_rs2_rdy;
  logic [1:0]    disp_branch_type;
  logic [W-1:0]  disp_pc, disp_imm, disp_rs1_val, disp_rs2_val, cdb_value;
  logic [T-1:0]  disp_rs1_tag, disp_rs2_tag, disp_rob_tag, cdb_tag;
  logic          cdb_valid, iss_ready;
  logic          disp_ready, iss_valid, iss_gate_sel;
  logic [1:0]    iss_branch_type;
  logic [W-1:0]  iss_pc, iss_imm, iss_reg_a, iss_reg_b;
  logic [T-1:0]  iss_rob_tag;
  logic [CW-1:0] count;

  always #5 CLK = ~CLK;

  branch_rs #(.NUM_ENTRIES(N), .WORD_W(W), .TAG_W(T)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_branch_type(disp_branch_type), .disp_gate_sel(disp_gate_sel),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rob_tag(disp_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_branch_type(iss_branch_type), .iss_gate_sel(iss_gate_sel),
    .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_reg_a(iss_reg_a), .iss_reg_b(iss_reg_b),
    .iss_rob_tag(iss_rob_tag), .count(count)
  );

  // Behavioural model: an age-ordered list of waiting branches plus the issue slot.
  typedef struct {
    logic [1:0]   btype;
    logic         gate;
    logic [W-1:0] pc, imm, a, b;
    logic         ar, br;
    logic [T-1:0] atag, btag, rob;
  } mentry_t;

  mentry_t mq[$];
  mentry_t m_iss;
  logic    m_iss_v;
  int      n_cmp = 0;
  int      n_bad = 0;

  logic [4*W+T+2:0] dut_vec;
  assign dut_vec = {iss_pc, iss_imm, iss_reg_a, iss_reg_b, iss_rob_tag, iss_branch_type,
                    iss_gate_sel};

  function automatic logic [4*W+T+2:0] model_vec();
    return {m_iss.pc, m_iss.imm, m_iss.a, m_iss.b, m_iss.rob, m_iss.btype, m_iss.gate};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_iss   = '{default: '0};
    m_iss_v = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    int      cand = -1;
    bit      accept;
    mentry_t e;
    accept = (mq.size() < N) && !flush;
    if (flush) begin
      mq.delete();
      m_iss_v = 1'b0;
      return;
    end
    foreach (mq[i]) if (cand < 0 && mq[i].ar && mq[i].br) cand = i;
    if (cand >= 0 && (!m_iss_v || iss_ready)) begin
      m_iss   = mq[cand];
      m_iss_v = 1'b1;
      mq.delete(cand);
    end else if (iss_ready) begin
      m_iss_v = 1'b0;
    end
    foreach (mq[i]) begin
      if (cdb_valid && !mq[i].ar && mq[i].atag == cdb_tag) begin
        mq[i].a = cdb_value; mq[i].ar = 1'b1;
      end
      if (cdb_valid && !mq[i].br && mq[i].btag == cdb_tag) begin
        mq[i].b = cdb_value; mq[i].br = 1'b1;
      end
    end
    if (disp_valid && accept) begin
      e.btype = disp_branch_type; e.gate = disp_gate_sel;
      e.pc = disp_pc; e.imm = disp_imm; e.rob = disp_rob_tag;
      e.a = disp_rs1_val; e.ar = disp_rs1_rdy; e.atag = disp_rs1_tag;
      e.b = disp_rs2_val; e.br = disp_rs2_rdy; e.btag = disp_rs2_tag;
      if (!disp_rs1_rdy && cdb_valid && cdb_tag == disp_rs1_tag) begin
        e.a = cdb_value; e.ar = 1'b1;
      end
      if (!disp_rs2_rdy && cdb_valid && cdb_tag == disp_rs2_tag) begin
        e.b = cdb_value; e.br = 1'b1;
      end
      mq.push_back(e);
    end
  endfunction

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_branch_type = 2'd0; disp_gate_sel = 1'b0;
    disp_pc = '0; disp_imm = '0; disp_rs1_val = '0; disp_rs2_val = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    disp_rob_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; iss_ready = 1'b1;
  endtask

  task automatic set_disp(input logic [W-1:0] pc, input logic [W-1:0] imm,
                          input logic [1:0] bt, input logic [W-1:0] a, input logic ar,
                          input logic [T-1:0] at, input logic [W-1:0] b, input logic br,
                          input logic [T-1:0] btg, input logic [T-1:0] rob);
    disp_valid = 1'b1; disp_pc = pc; disp_imm = imm; disp_branch_type = bt;
    disp_gate_sel = rob[0];
    disp_rs1_val = a; disp_rs1_rdy = ar; disp_rs1_tag = at;
    disp_rs2_val = b; disp_rs2_rdy = br; disp_rs2_tag = btg; disp_rob_tag = rob;
  endtask

  task automatic set_cdb(input logic [T-1:0] tag, input logic [W-1:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    #12;
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
    n_cmp++; if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_iss_fields: got %h want 0", dut_vec); end
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_basic();
    idle();
    set_disp(32'h100, 32'h20, 2'd0, 32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 4'd1);
    tick(); idle();
    n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL basic_count1: got %0d want 1", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_issue: got %b want 0", iss_valid); end
    tick();
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL basic_iss_valid: got %b want 1", iss_valid); end
    n_cmp++; if ({iss_reg_a, iss_reg_b, iss_pc} !== {32'd5, 32'd5, 32'h100}) begin
      n_bad++; $display("FAIL basic_fields: got a=%h b=%h pc=%h want 5 5 100", iss_reg_a, iss_reg_b, iss_pc);
    end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL basic_count0: got %0d want 0", count); end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL basic_model: got %h want %h", dut_vec, model_vec()); end
    tick();
  endtask

  task automatic test_wakeup();
    idle();
    set_disp(32'h200, 32'h8, 2'd1, 32'd7, 1'b1, 4'd0, 32'd0, 1'b0, 4'd3, 4'd2);
    tick(); idle();
    set_cdb(4'd4, 32'hBAD);
    tick(); idle();
    set_cdb(4'd3, 32'hDEAD);
    tick(); idle();
    n_cmp++; if (iss_valid !== 1'b0 || count !== CW'(1)) begin
      n_bad++; $display("FAIL wake_wrong_tag: got valid=%b count=%0d want 0 1", iss_valid, count);
    end
    tick();
    n_cmp++; if (iss_valid !== 1'b1 || iss_reg_b !== 32'hDEAD) begin
      n_bad++; $display("FAIL wake_issue: got valid=%b b=%h want 1 dead", iss_valid, iss_reg_b);
    end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL wake_model: got %h want %h", dut_vec, model_vec()); end
    tick();
  endtask

  task automatic test_order();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(32'h1000 + 32'(i * 4), 32'h4, 2'd2, 32'd0, 1'b0, T'(8 + i), 32'(i), 1'b1, 4'd0, T'(i));
      tick(); idle();
    end
    set_disp(32'h2000, 32'h4, 2'd0, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd15);
    set_cdb(4'd10, 32'h1111);
    #1;
    n_cmp++; if (count !== CW'(4) || disp_ready !== 1'b0) begin
      n_bad++; $display("FAIL order_full: got count=%0d ready=%b want 4 0", count, disp_ready);
    end
    tick(); idle();
    n_cmp++; if (count !== CW'(4)) begin n_bad++; $display("FAIL order_no_accept: got %0d want 4", count); end
    tick();
    n_cmp++; if (iss_valid !== 1'b1 || iss_rob_tag !== 4'd2) begin
      n_bad++; $display("FAIL order_first: got valid=%b rob=%0d want 1 2", iss_valid, iss_rob_tag);
    end
    for (int k = 0; k < 3; k++) begin
      idle(); iss_ready = 1'b0;
      set_cdb((k == 0) ? 4'd11 : (k == 1) ? 4'd9 : 4'd8, 32'h2222 + 32'(k));
      tick();
    end
    idle(); iss_ready = 1'b0;
    tick();
    n_cmp++; if (iss_rob_tag !== 4'd2 || count !== CW'(3)) begin
      n_bad++; $display("FAIL order_hold: got rob=%0d count=%0d want 2 3", iss_rob_tag, count);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      logic [T-1:0] want;
      want = (k == 2) ? 4'd3 : T'(k);
      tick();
      n_cmp++; if (iss_valid !== 1'b1 || iss_rob_tag !== want) begin
        n_bad++; $display("FAIL order_seq%0d: got rob=%0d want %0d", k, iss_rob_tag, want);
      end
    end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL order_model: got %h want %h", dut_vec, model_vec()); end
    tick();
  endtask

  task automatic test_backpressure();
    idle(); iss_ready = 1'b0;
    set_disp(32'h300, 32'h0, 2'd0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd5);
    tick(); idle(); iss_ready = 1'b0;
    set_disp(32'h310, 32'h0, 2'd1, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd6);
    tick(); idle(); iss_ready = 1'b0;
    set_disp(32'h320, 32'h0, 2'd2, 32'd5, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd7);
    tick(); idle(); iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (iss_valid !== 1'b1 || iss_pc !== 32'h300 || count !== CW'(2)) begin
        n_bad++; $display("FAIL bp_hold%0d: got valid=%b pc=%h count=%0d want 1 300 2", k, iss_valid, iss_pc, count);
      end
      tick();
    end
    idle();
    tick();
    n_cmp++; if (iss_pc !== 32'h310 || count !== CW'(1)) begin
      n_bad++; $display("FAIL bp_first: got pc=%h count=%0d want 310 1", iss_pc, count);
    end
    tick();
    n_cmp++; if (iss_valid !== 1'b1 || iss_pc !== 32'h320 || count !== '0) begin
      n_bad++; $display("FAIL bp_second: got valid=%b pc=%h count=%0d want 1 320 0", iss_valid, iss_pc, count);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    set_disp(32'h400, 32'h10, 2'd0, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0, 4'd9);
    set_cdb(4'd6, 32'h1234);
    tick(); idle();
    n_cmp++; if (count !== CW'(1) || iss_valid !== 1'b0) begin
      n_bad++; $display("FAIL bypass_n1: got count=%0d valid=%b want 1 0", count, iss_valid);
    end
    tick();
    n_cmp++; if (iss_valid !== 1'b1 || iss_reg_a !== 32'h1234) begin
      n_bad++; $display("FAIL bypass_issue: got valid=%b a=%h want 1 1234", iss_valid, iss_reg_a);
    end
    tick();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 5; i++) begin
      iss_ready = 1'b0;
      set_disp(32'h600 + 32'(i), 32'h0, 2'd0, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, T'(10 + i));
      tick(); idle();
    end
    n_cmp++; if (count !== CW'(4) || iss_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_setup: got count=%0d valid=%b want 4 1", count, iss_valid);
    end
    iss_ready = 1'b0;
    set_disp(32'h500, 32'h0, 2'd0, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd3);
    flush = 1'b1;
    #1;
    n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready_low: got %b want 0", disp_ready); end
    tick(); idle();
    #1;
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_clear: got count=%0d valid=%b ready=%b want 0 0 1", count, iss_valid, disp_ready);
    end
    tick();
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_not_stored: got count=%0d valid=%b want 0 0", count, iss_valid);
    end
  endtask

  task automatic test_async_reset();
    idle(); iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(32'h700 + 32'(i), 32'h0, 2'd1, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, T'(i));
      tick();
    end
    idle();
    #2 nRST = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || dut_vec !== '0) begin
      n_bad++; $display("FAIL async_reset: got count=%0d valid=%b ready=%b fields=%h", count, iss_valid, disp_ready, dut_vec);
    end
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      disp_valid       = ($urandom_range(0, 9) < 6);
      disp_branch_type = 2'($urandom_range(0, 2));
      disp_gate_sel    = 1'($urandom_range(0, 1));
      disp_pc          = $urandom;
      disp_imm         = $urandom;
      disp_rs1_val     = $urandom;
      disp_rs2_val     = $urandom;
      disp_rs1_rdy     = 1'($urandom_range(0, 1));
      disp_rs2_rdy     = 1'($urandom_range(0, 1));
      disp_rs1_tag     = T'($urandom_range(0, 7));
      disp_rs2_tag     = T'($urandom_range(0, 7));
      disp_rob_tag     = T'($urandom_range(0, 15));
      cdb_valid        = 1'($urandom_range(0, 1));
      cdb_tag          = T'($urandom_range(0, 7));
      cdb_value        = $urandom;
      iss_ready        = ($urandom_range(0, 9) < 7);
      flush            = ($urandom_range(0, 49) == 0);
      #1;
      n_cmp++; if (disp_ready !== 1'((mq.size() < N) && !flush)) begin
        n_bad++; $display("FAIL rand_disp_ready c%0d: got %b want %b", c, disp_ready, (mq.size() < N) && !flush);
      end
      tick();
      n_cmp++; if (count !== CW'(mq.size())) begin
        n_bad++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, mq.size());
      end
      n_cmp++; if (iss_valid !== m_iss_v) begin
        n_bad++; $display("FAIL rand_iss_valid c%0d: got %b want %b", c, iss_valid, m_iss_v);
      end
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL rand_iss_fields c%0d: got %h want %h", c, dut_vec, model_vec());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_order();
    test_backpressure();
    test_bypass();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_rs.md
# branch_rs

Four-entry reservation station directly upstream of the branch functional unit. It accepts dispatched conditional branches, holds them until both source operands are available, and captures missing operands from the common data bus (CDB). It issues the oldest ready branch through a registered valid/ready output whose fields map one-to-one onto the branch FU inputs.

## Interface
Parameters:
- NUM_ENTRIES, 4, station depth (≥2)
- WORD_W, 32, operand/PC/immediate width
- TAG_W, 4, ROB/CDB tag width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- flush  in  1  squash every entry and the issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept this cycle
- disp_branch_type  in  2  0 EQ/NE, 1 signed LT/GE, 2 unsigned LT/GE
- disp_gate_sel  in  1  0 = take on zero, 1 = take on ~zero
- disp_pc  in  WORD_W  branch PC
- disp_imm  in  WORD_W  sign-extended offset
- disp_rs1_val, disp_rs2_val  in  WORD_W  operand values
- disp_rs1_rdy, disp_rs2_rdy  in  1  operand value valid
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  producer tag when not ready
- disp_rob_tag  in  TAG_W  branch's own ROB tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  WORD_W  broadcast value
- iss_valid  out  1  issue register holds a branch
- iss_ready  in  1  downstream accepts
- iss_branch_type, iss_gate_sel, iss_pc, iss_imm  out  2/1/WORD_W/WORD_W  issued fields
- iss_reg_a, iss_reg_b  out  WORD_W  rs1/rs2 values
- iss_rob_tag  out  TAG_W  issued ROB tag
- count  out  $clog2(NUM_ENTRIES+1)  occupied entries

## Operation
- Collapsing queue: index 0 is oldest; valid entries are contiguous from 0.
- disp_ready = (count < NUM_ENTRIES) && !flush. There is no credit for a same-cycle issue.
- Dispatch (disp_valid && disp_ready): the entry is written at index count − (1 if an entry issues this edge).
- Dispatch bypass: if a disp operand is not ready and cdb_valid && cdb_tag == disp_rsX_tag in the same cycle, the entry stores cdb_value with ready = 1.
- Wakeup: every valid entry with a not-ready operand whose tag equals cdb_tag (cdb_valid) captures cdb_value at the edge. Both operands can wake in the same cycle.
- Select: the lowest-index entry with both operands ready, evaluated combinationally from registered state.
- Issue: when a candidate exists and (!iss_valid || iss_ready), the candidate loads the issue register. It is removed at the same edge and higher entries shift down one.
- If iss_valid && !iss_ready, the issue register holds all fields stable and no entry is removed.
- flush: at the next edge all entries become invalid, iss_valid = 0, and count = 0. It overrides dispatch, wakeup and issue in the same cycle.

## Timing
- Reset values: all entries invalid, iss_valid 0, all iss_* fields 0, count 0, disp_ready 1.
- Dispatch with both operands ready in cycle N: the entry is valid in N+1, selected in N+1, and iss_valid = 1 in N+2. Minimum latency is 2 cycles.
- CDB wakeup in cycle N: the entry becomes eligible in N+1 and issues with iss_valid in N+2.
- Back-to-back: with iss_ready held at 1, one branch issues per cycle.
- Full, with simultaneous issue: disp_ready stays 0 for that cycle, and dispatch resumes the next cycle.
- Reset asserted mid-operation: state clears immediately, asynchronously, to the reset values.
- No operand is ever captured from a CDB tag that does not match.

## Structure
- types_pkg: add typedef branch_rs_entry_t (valid, branch_type, gate_sel, pc, imm, rs1/rs2 val/rdy/tag, rob_tag) and localparam BR_RS_ENTRIES = 4.
- branch_type encodings are shared with the branch FU and come from the package, not literals.
- One sub-module, branch_rs_select: a lowest-index-ready priority encoder producing found and idx.

## Test plan
- Reset, then dispatch {pc=0x100, imm=0x20, type 0, rs1=5, rs2=5, both ready} with iss_ready=1 → iss_valid=1 exactly 2 cycles later, iss_reg_a=iss_reg_b=5, iss_pc=0x100; count returns to 0.
- Dispatch with rs2 not ready (tag 3), then CDB {tag 3, value 0xDEAD} two cycles later → issue occurs 2 cycles after the broadcast, iss_reg_b=0xDEAD. A CDB with tag 4 has no effect.
- Dispatch 4 not-ready branches → count=4 and disp_ready=0. Waking entry 2 first → entry 2 issues first, and the remaining entries keep their order (0, 1, 3).
- Hold iss_ready=0 with two ready entries → iss_* stays stable and count stays 2. Raise iss_ready → the two branches issue in consecutive cycles, in age order.
- Dispatch whose rs1_tag matches cdb_tag in the same cycle → the stored rs1 value equals cdb_value, and the branch issues at N+2.
- flush while full, with iss_valid=1 and disp_valid=1 → next cycle count=0, iss_valid=0, disp_ready=1, and the dispatched branch is not stored.
